// File: rtl/dot_product_pkg.sv
// dot_product_pkg: width helpers, stage control struct and result narrowing for dot_product_stream
package dot_product_pkg;
  localparam int MAX_W = 64;
  localparam int MAX_ACC_W = 256;
  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;
  typedef struct packed {
    logic [MAX_W-1:0] val;
    logic             ovf;
  } narrow_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int acc_width(input int width, input int n, input int guard);
    return 2 * width + clog2(n) + guard;
  endfunction
  function automatic narrow_t narrow(input logic signed [MAX_ACC_W-1:0] v, input int w, input bit sat);
    narrow_t res;
    logic signed [MAX_ACC_W-1:0] hi, lo, r;
    hi = (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
    lo = ~hi;
    r = (sat && v > hi) ? hi : (sat && v < lo) ? lo : v;
    res.val = r[MAX_W-1:0];
    res.ovf = sat && (v > hi || v < lo);
    return res;
  endfunction
endpackage

// File: rtl/dot_product_stream_tree.sv
// dp_adder_tree: registered log2(N)-level pairwise signed reduction with stage control alongside
module dp_adder_tree
  import dot_product_pkg::*;
#(
  parameter int N    = 4,
  parameter int IN_W = 64
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 en,
  input  logic [N*IN_W-1:0]                    terms,
  input  stage_ctl_t                           terms_ctl,
  output logic signed [IN_W+clog2(N)-1:0]      sum,
  output stage_ctl_t                           sum_ctl
);
  localparam int L = clog2(N);
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int CNT = N >> l;
    localparam int W = IN_W + l;
    logic [CNT*W-1:0] d;
    stage_ctl_t c;
    if (l == 0) begin : g_in
      assign d = terms;
      assign c = terms_ctl;
    end else begin : g_add
      logic [CNT*W-1:0] nxt;
      for (genvar i = 0; i < CNT; i++) begin : g_i
        assign nxt[i*W +: W] = W'($signed(g_lvl[l-1].d[2*i*(W-1) +: W-1]))
                             + W'($signed(g_lvl[l-1].d[(2*i+1)*(W-1) +: W-1]));
      end
      // one tree level; valid cleared on reset, data only advances with the global enable
      always_ff @(posedge clk_in)
        if (!rst_in) c <= '0;
        else if (en) begin
          c <= g_lvl[l-1].c;
          d <= nxt;
        end
    end
  end
  assign sum = $signed(g_lvl[L].d);
  assign sum_ctl = g_lvl[L].c;
endmodule

// File: rtl/dot_product_stream.sv
// dot_product_stream: streaming N-lane dot product with group accumulation; DOT_PRODUCT_SAT_EN selects saturation
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int N     = 4,
  parameter int GUARD = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [N*WIDTH-1:0] x_in,
  input  logic [N*WIDTH-1:0] y_in,
  input  logic               valid_in,
  input  logic               last_in,
  output logic               ready_out,
  output logic [WIDTH-1:0]   out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               overflow_out
);
  localparam int L = clog2(N);
  localparam int PW = 2 * WIDTH;
  localparam int TW = PW + L;
  localparam int ACC_W = acc_width(WIDTH, N, GUARD);
`ifdef DOT_PRODUCT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic advance;
  logic [N*PW-1:0] prod, prod_nxt;
  stage_ctl_t s1_ctl, t_ctl, a_ctl;
  logic signed [TW-1:0] tree_sum;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic first;
  narrow_t nr;
  assign advance = !valid_out || ready_in;
  assign ready_out = advance;
  for (genvar k = 0; k < N; k++) begin : g_mul
    assign prod_nxt[k*PW +: PW] = PW'($signed(x_in[k*WIDTH +: WIDTH])) * PW'($signed(y_in[k*WIDTH +: WIDTH]));
  end
  // product stage: capture lane products of an accepted beat
  always_ff @(posedge clk_in)
    if (!rst_in) s1_ctl <= '0;
    else if (advance) begin
      s1_ctl <= '{valid: valid_in, last: last_in};
      prod <= prod_nxt;
    end
  dp_adder_tree #(.N(N), .IN_W(PW)) u_tree (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .en(advance),
    .terms(prod),
    .terms_ctl(s1_ctl),
    .sum(tree_sum),
    .sum_ctl(t_ctl)
  );
  assign acc_nxt = (first ? '0 : acc) + ACC_W'(tree_sum);
  // accumulator: first gates the old sum so a closed group restarts from zero
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      a_ctl <= '0;
      acc <= '0;
      first <= 1'b1;
    end else if (advance) begin
      a_ctl <= t_ctl;
      if (t_ctl.valid) begin
        acc <= acc_nxt;
        first <= t_ctl.last;
      end
    end
  assign nr = narrow(MAX_ACC_W'(acc >>> FRAC), WIDTH, SAT_EN);
  // output register: load scaled group result when a last beat leaves the accumulator
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      out <= '0;
      valid_out <= 1'b0;
      overflow_out <= 1'b0;
    end else if (advance) begin
      valid_out <= a_ctl.valid && a_ctl.last;
      if (a_ctl.valid && a_ctl.last) begin
        out <= WIDTH'(nr.val);
        overflow_out <= nr.ovf;
      end
    end
endmodule

// File: doc/dot_product_stream.md
# dot_product_stream

Streaming, parametrised N-lane dot-product engine with valid/ready handshake, multi-beat accumulation and selectable fixed-point scaling. It replaces the fixed 4-lane, always-flowing dot product in the transform path. Vector/matrix stages feed one N-wide operand pair per beat. A `last_in` flag closes an accumulation group, so dot products longer than N are built across beats. It emits one scaled WIDTH-bit result per group.

## Interface
- WIDTH, 32: operand and result width, signed two's complement.
- FRAC, 16: fractional bits. 0 selects integer mode. Legal range 0..WIDTH-1.
- N, 4: lanes per beat. Power of two, 2..16.
- GUARD, 8: extra accumulator headroom bits.
- clk_in  in  1  single clock; all logic on its rising edge.
- rst_in  in  1  reset, synchronous, active-low.
- x_in  in  N*WIDTH  operand vector x; lane k is bits [k*WIDTH +: WIDTH].
- y_in  in  N*WIDTH  operand vector y, same packing.
- valid_in  in  1  beat present.
- last_in  in  1  beat closes the current accumulation group.
- ready_out  out  1  engine accepts a beat this cycle.
- out  out  WIDTH  group result.
- valid_out  out  1  out holds a result.
- ready_in  in  1  downstream accepts the result.
- overflow_out  out  1  result was saturated. Qualified by valid_out.

## Operation
- Beat accepted when valid_in && ready_out.
- Pipeline stages:
  - S1: N signed products, 2*WIDTH each.
  - T1..TL, L = log2(N): pairwise adder tree; each level widens by 1 bit.
  - A: accumulator, width ACC_W = 2*WIDTH + L + GUARD.
  - O: output register.
- Each stage carries a valid bit and a last bit.
- Accumulator stage:
  - Sum into acc = (first ? 0 : acc) + tree_sum.
  - `first` is set at reset and after every last beat.
  - Non-last beat: acc updated, nothing emitted.
  - Last beat: scaled value loaded into O, valid_out raised, acc cleared, first set.
- Scaling: acc arithmetic-shifted right by FRAC (floor; no rounding), then narrowed to WIDTH (see Configuration).
- A group of exactly one beat is the plain N-lane dot product.
- Backpressure uses a global stall, advance = !valid_out || ready_in.
  - ready_out = advance.
  - When advance is 0, every stage register, acc and first hold.
- Reset while rst_in = 0:
  - All stage valid bits, valid_out, overflow_out and acc go to 0; first goes to 1.
  - out goes to 0.
  - Partial groups in flight are discarded.
- Reset values: ready_out 1 (valid_out is 0), out 0, valid_out 0, overflow_out 0.

## Timing
- Latency from accepting a last beat to valid_out = L + 3 cycles, unstalled: S1, L tree levels, A, O. N=4 gives 5.
- Throughput: one beat per cycle while ready_in is held 1.
- A result holds stable until the cycle with valid_out && ready_in.
- Simultaneous handshakes:
  - Result consumed and new beat accepted in the same cycle: legal, no bubble.
  - Back-to-back last beats produce results on consecutive cycles.
- valid_in = 0 cycles insert bubbles. Bubbles do not disturb acc.
- x_in, y_in and last_in are ignored unless valid_in && ready_out.

## Configuration
- DOT_PRODUCT_SAT_EN defined:
  - Shifted acc outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] clamps to the nearest bound.
  - overflow_out = 1 with that result.
- DOT_PRODUCT_SAT_EN undefined:
  - Result is the low WIDTH bits of the shifted acc (wrap).
  - overflow_out is tied to 0.

## Structure
- Package dot_product_pkg holds:
  - Width helpers: ACC_W and L computed from WIDTH/N/GUARD via a clog2-based function.
  - A stage-control struct typedef {valid, last}.
  - The saturate/narrow function.
- One sub-module, dp_adder_tree:
  - Parameters N and IN_W.
  - Registered log2(N)-level reduction with a shared enable (advance).
  - Carries the valid/last struct alongside the data.

## Test plan
- Fixed-point single beat, defaults, SAT on:
  - Stimulus: all lanes x = 0x00010000, y = 0x00010000, last = 1.
  - Response: out = 0x00040000 after 5 cycles, overflow_out 0.
- Integer group, FRAC = 0, N = 4:
  - Stimulus: beat 1 x = {1,2,3,4}, y = {1,1,1,1}, last 0; beat 2 x = {5,6,7,8}, y = {1,1,1,1}, last 1.
  - Response: single result out = 36; no valid_out after beat 1.
- Backpressure:
  - Stimulus: stream 8 one-beat groups with values 1..8 while ready_in toggles 1,0,0,1,...
  - Response: results 1..8 in order, none lost or duplicated; ready_out = 0 exactly when valid_out && !ready_in.
- Saturation, FRAC = 16:
  - Stimulus: all lanes x = y = 0x7FFF0000.
  - Response with DOT_PRODUCT_SAT_EN: out = 0x7FFFFFFF, overflow_out 1.
  - Response without the macro: out = low 32 bits of the wrapped shifted sum, overflow_out 0.
- Negative floor, FRAC = 16:
  - Stimulus: one lane 0xFFFF8000 (-0.5) × 0x00000001; other lanes 0.
  - Response: out = 0xFFFFFFFF (-1 LSB).
- Reset mid-group:
  - Stimulus: beat with last 0 and value 100; drop rst_in for 1 cycle; then a one-beat group of value 5.
  - Response: out = 5, not 105; all outputs 0 during reset.
